// File: rtl/pipefetch_fifo_if.sv
// Pipelined Wishbone read bus between the instruction prefetcher (master)
// and the instruction memory (slave).
interface pipefetch_fifo_if #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32
);
  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     ack;
  logic                     stall;
  logic                     err;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (
    output cyc, stb, we, addr, wdata,
    input  ack, stall, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata,
    output ack, stall, err, rdata
  );
endinterface

// File: rtl/pipefetch_fifo.sv
// Pipelined instruction prefetch: streams sequential Wishbone reads into a
// small buffer and hands one instruction per clock to decode.
module pipefetch_fifo #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int LGFIFO        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic                     i_stalled_n,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0]    o_i,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic                     o_valid,
  output logic                     o_illegal,
  pipefetch_fifo_if.master         wb
);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int CW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

  state_t            state, state_n;
  logic              cyc, stb, cyc_n, stb_n;
  logic [AW-1:0]     addr, addr_n, pc, target;
  logic [CW-1:0]     fill, fill_n, outst, outst_n;
  logic [CW:0]       inflight;
  logic              room;
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0]     mem [DEPTH];
  logic              ill_mem [DEPTH];
  logic [DW-1:0]     last_i;
  logic              flush, live, ack_v, err_v, push, pop, accept;

  // Flushes outrank bus responses; responses only count while the cycle is ours.
  assign flush  = i_new_pc | i_clear_cache;
  assign target = i_new_pc ? i_pc : pc;
  assign live   = cyc && (state == BUSY) && !flush;
  assign err_v  = live && wb.err;
  assign ack_v  = live && wb.ack && !wb.err;
  assign push   = ack_v | err_v;
  assign pop    = o_valid && i_stalled_n && !flush;
  assign accept = stb && !wb.stall && !flush && !err_v;

  always_comb begin
    state_n  = state;
    fill_n   = fill + CW'(push) - CW'(pop);
    outst_n  = outst + CW'(accept) - CW'(ack_v);
    addr_n   = accept ? addr + AW'(1) : addr;
    cyc_n    = 1'b0;
    stb_n    = 1'b0;
    inflight = '0;
    room     = 1'b0;
    if (flush) begin
      state_n = BUSY;
      fill_n  = '0;
      outst_n = '0;
      addr_n  = target;
    end else if (err_v) begin
      state_n = HALTED;
      outst_n = '0;
    end else if (state == BUSY) begin
      // Buffered plus in-flight words may never exceed the buffer depth.
      inflight = {1'b0, fill_n} + {1'b0, outst_n};
      room     = inflight < DEPTH_L;
      stb_n    = room;
      cyc_n    = room || (outst_n != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc    <= 1'b0;
      stb    <= 1'b0;
      addr   <= '0;
      fill   <= '0;
      outst  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pc     <= '0;
      last_i <= '0;
    end else begin
      cyc   <= cyc_n;
      stb   <= stb_n;
      addr  <= addr_n;
      fill  <= fill_n;
      outst <= outst_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pc     <= target;
      end else begin
        if (push) wr_ptr <= wr_ptr + LGFIFO'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + LGFIFO'(1);
          pc     <= pc + AW'(1);
        end
      end
      if (pop) last_i <= mem[rd_ptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr]     <= wb.rdata;
      ill_mem[wr_ptr] <= err_v;
    end
  end

  // An empty buffer keeps showing the last instruction handed out.
  assign o_valid   = (fill != '0);
  assign o_i       = o_valid ? mem[rd_ptr] : last_i;
  assign o_illegal = o_valid && ill_mem[rd_ptr];
  assign o_pc      = pc;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = 1'b0;
  assign wb.addr  = addr;
  assign wb.wdata = '0;
endmodule
